// File: rtl/riscv_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the LSU, one transaction at a time.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module riscv_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ready,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t                state;
    owner_t                owner;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic fetch_win;
    logic grant_if;
    logic grant_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);
    logic [2:0] starve_cnt;

    // Data normally wins; fetch takes over once data has been granted STARVE_LIMIT times in a row over it.
    assign fetch_win = if_req & (~d_req | (starve_cnt == STARVE_LIM));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (grant_if) begin
            starve_cnt <= 3'd0;
        end else if (grant_d) begin
            if (!if_req)
                starve_cnt <= 3'd0;
            else if (starve_cnt != 3'd7)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign fetch_win = if_req & ~d_req;
`endif

    assign grant_if = (state == IDLE) & ~rst & fetch_win;
    assign grant_d  = (state == IDLE) & ~rst & d_req & ~fetch_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= OWN_FETCH;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        addr_q  <= d_addr;
                        we_q    <= d_we;
                        be_q    <= d_be;
                        wdata_q <= d_wdata;
                        owner   <= OWN_DATA;
                        state   <= REQ;
                    end else if (grant_if) begin
                        addr_q  <= if_addr;
                        we_q    <= 1'b0;
                        be_q    <= '1;
                        wdata_q <= '0;
                        owner   <= OWN_FETCH;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready)
                        state <= RESP;
                end
                RESP: begin
                    if (mem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign mem_req   = (state == REQ);
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state != IDLE);

    // Response passes straight through to whichever side owns the transaction.
    assign if_rvalid = (state == RESP) & mem_rvalid & (owner == OWN_FETCH);
    assign d_rvalid  = (state == RESP) & mem_rvalid & (owner == OWN_DATA);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: hand-computed expectations checked with immediate assertions.
module tb_riscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int tests = 0;
    int fails = 0;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    riscv_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then changed and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_be = '0; d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        mem_rdata = 32'h0000_0055;
        settle();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_we_be", {27'd0, mem_we, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_gnt_rvalid_busy", {27'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, busy}, 32'd0);
        chk("rst_rdata_follow", if_rdata, 32'h0000_0055);

        // Single fetch, best-case timing
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0000;
        settle();
        chk("t1_c0_gnt", {30'd0, if_gnt, d_gnt}, 32'h2);
        tick();
        if_req = 1'b0; mem_ready = 1'b1;
        settle();
        chk("t1_c1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("t1_c1_addr", mem_addr, 32'h0);
        chk("t1_c1_we_be", {27'd0, mem_we, mem_be}, 32'h0F);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_006F;
        settle();
        chk("t1_c2_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'h2);
        chk("t1_c2_rdata", if_rdata, 32'h0000_006F);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t1_c3_idle", {29'd0, busy, if_rvalid, d_rvalid}, 32'd0);

        // Collision: data store wins, then fetch is granted
        if_req = 1'b1; if_addr = 32'h0000_0004;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
        settle();
        chk("t2_gnt_data_first", {30'd0, if_gnt, d_gnt}, 32'h1);
        tick();
        d_req = 1'b0; mem_ready = 1'b1;
        settle();
        chk("t2_mem_we_req", {30'd0, mem_req, mem_we}, 32'h3);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t2_mem_addr", mem_addr, 32'h0000_0100);
        chk("t2_no_gnt_in_req", {30'd0, if_gnt, d_gnt}, 32'd0);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1;
        settle();
        chk("t2_store_ack", {30'd0, if_rvalid, d_rvalid}, 32'h1);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t2_fetch_next", {30'd0, if_gnt, d_gnt}, 32'h2);

        // Ready stall in REQ, with a data request arriving meanwhile
        tick();
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h3; d_addr = 32'h0000_0200; d_wdata = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("t3_stall%0d_req_busy", i), {30'd0, mem_req, busy}, 32'h3);
            chk($sformatf("t3_stall%0d_addr", i), mem_addr, 32'h0000_0004);
            chk($sformatf("t3_stall%0d_wdata", i), mem_wdata, 32'h0);
            chk($sformatf("t3_stall%0d_gnt", i), {30'd0, if_gnt, d_gnt}, 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        settle();
        chk("t3_stall3_req", {31'd0, mem_req}, 32'd1);
        chk("t3_stall3_addr", mem_addr, 32'h0000_0004);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
        settle();
        chk("t3_fetch_resp", {29'd0, if_rvalid, d_rvalid, d_gnt}, 32'h4);
        chk("t3_fetch_rdata", if_rdata, 32'h0000_1234);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t3_waiting_data_gnt", {30'd0, if_gnt, d_gnt}, 32'h1);

        // Spurious mem_rvalid while in REQ
        tick();
        d_req = 1'b0; mem_rvalid = 1'b1;
        settle();
        chk("t6_req_spurious", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        tick();
        mem_rvalid = 1'b0; mem_ready = 1'b1;
        settle();
        chk("t6_still_req", {31'd0, mem_req}, 32'd1);
        chk("t6_load_addr_we_be", {mem_addr[27:0], mem_we, 3'd0} ^ {28'd0, 4'd0} | {28'd0, 4'd0} | 32'(mem_be), 32'h0000_2003);

        // Reset while in RESP; late mem_rvalid must be ignored
        tick();
        mem_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        settle();
        chk("t5_rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk("t5_rst_busy_req", {30'd0, busy, mem_req}, 32'd0);
        chk("t5_rst_regs", mem_addr | mem_wdata | 32'(mem_be) | 32'(mem_we), 32'd0);
        tick();
        settle();
        chk("t6_idle_spurious", {29'd0, if_rvalid, d_rvalid, busy}, 32'd0);
        mem_rvalid = 1'b0;

        // Starvation: both requests held through six arbitrations
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0008;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0300;
        for (int k = 1; k <= 6; k++) begin
            logic exp_fetch;
            exp_fetch = GUARD && (k == 5);
            settle();
            chk($sformatf("t4_arb%0d_gnt", k), {30'd0, if_gnt, d_gnt},
                exp_fetch ? 32'h2 : 32'h1);
            tick();
            mem_ready = 1'b1;
            settle();
            chk($sformatf("t4_arb%0d_addr", k), mem_addr,
                exp_fetch ? 32'h0000_0008 : 32'h0000_0300);
            tick();
            mem_ready = 1'b0; mem_rvalid = 1'b1;
            settle();
            chk($sformatf("t4_arb%0d_rvalid", k), {30'd0, if_rvalid, d_rvalid},
                exp_fetch ? 32'h2 : 32'h1);
            tick();
            mem_rvalid = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
